// File: rtl/opb_register_master_pkg.sv
// Shared FSM state encoding and response status codes for the OPB register master.
// No logic; imported by the master top.
package opb_register_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        XFER    = 3'd2,
        BACKOFF = 3'd3,
        RESP    = 3'd4
    } state_e;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_ERR     = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;
    localparam logic [1:0] RSP_RETRY   = 2'd3;

endpackage

// File: rtl/opb_register_master_wdog.sv
// Purpose: counts cycles a transaction spends waiting on the bus; flags expiry on the last allowed cycle.
// Latency: expired is combinational from the count, asserted in the C_WDOG_CYCLES-th enabled cycle.
// Backpressure: none; the count saturates at expiry until cleared.
module opb_register_master_wdog #(
    parameter int unsigned C_WDOG_CYCLES = 64
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(C_WDOG_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CW'(C_WDOG_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/opb_register_master.sv
// Purpose: single-outstanding OPB master turning cmd_* requests into bus transfers; OPB_REGISTER_MASTER_RETRY_EN enables retry reissue.
// Latency: accept -> REQ next cycle, XFER one cycle after grant, RESP one cycle after slave response.
// Backpressure: cmd_ready only in IDLE; RESP holds rsp_* stable until rsp_ready.
module opb_register_master
    import opb_register_master_pkg::*;
#(
    parameter int unsigned C_OPB_AWIDTH  = 32,
    parameter int unsigned C_OPB_DWIDTH  = 32,
    parameter int unsigned C_MAX_RETRIES = 15,
    parameter int unsigned C_WDOG_CYCLES = 64
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
    input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
    input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_status,
    output logic                      M_request,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    input  logic                      OPB_MGrant,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_timeout
);

`ifdef OPB_REGISTER_MASTER_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif
    localparam int unsigned RCW = $clog2(C_MAX_RETRIES + 2);

    state_e                      state_q, state_d;
    logic                        rnw_q, rnw_d;
    logic [C_OPB_AWIDTH-1:0]     addr_q, addr_d;
    logic [C_OPB_DWIDTH-1:0]     wdata_q, wdata_d;
    logic [C_OPB_DWIDTH/8-1:0]   be_q, be_d;
    logic [C_OPB_DWIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                  status_q, status_d;
    logic [RCW-1:0]              retry_cnt_q, retry_cnt_d;
    logic                        accept;
    logic                        wdog_en;
    logic                        wdog_expired;

    assign accept  = cmd_valid && (state_q == IDLE);
    assign wdog_en = (state_q == REQ) || (state_q == XFER);

    opb_register_master_wdog #(
        .C_WDOG_CYCLES (C_WDOG_CYCLES)
    ) u_wdog (
        .core_clk (OPB_Clk),
        .arst_n   (OPB_Rst_n),
        .enable   (wdog_en),
        .clear    (accept),
        .expired  (wdog_expired)
    );

    always_comb begin
        state_d     = state_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        status_d    = status_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = REQ;
                    rnw_d       = cmd_rnw;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    be_d        = cmd_be;
                    rdata_d     = '0;
                    status_d    = RSP_OK;
                    retry_cnt_d = '0;
                end
            end
            REQ: begin
                if (wdog_expired) begin
                    state_d  = RESP;
                    status_d = RSP_TIMEOUT;
                end else if (OPB_MGrant) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                // Bus timeout and local watchdog share top priority.
                if (OPB_timeout || wdog_expired) begin
                    state_d  = RESP;
                    status_d = RSP_TIMEOUT;
                end else if (OPB_retry) begin
                    if (RetryEn && (retry_cnt_q != RCW'(C_MAX_RETRIES))) begin
                        state_d     = BACKOFF;
                        retry_cnt_d = retry_cnt_q + 1'b1;
                    end else begin
                        state_d  = RESP;
                        status_d = RSP_RETRY;
                    end
                end else if (OPB_errAck) begin
                    state_d  = RESP;
                    status_d = RSP_ERR;
                end else if (OPB_xferAck) begin
                    state_d  = RESP;
                    status_d = RSP_OK;
                    rdata_d  = rnw_q ? OPB_DBus : '0;
                end
            end
            BACKOFF: begin
                state_d = REQ;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q     <= IDLE;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            status_q    <= RSP_OK;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    // Bus drives decode straight from the state flop so reset removes them without waiting for a clock.
    assign cmd_ready  = (state_q == IDLE);
    assign M_request  = (state_q == REQ);
    assign M_select   = (state_q == XFER);
    assign M_RNW      = M_select && rnw_q;
    assign M_ABus     = M_select ? addr_q : '0;
    assign M_BE       = M_select ? be_q : '0;
    assign M_DBus     = (M_select && !rnw_q) ? wdata_q : '0;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rsp_valid ? rdata_q : '0;
    assign rsp_status = rsp_valid ? status_q : RSP_OK;

endmodule

// File: doc/opb_register_master.md
OPB_REGISTER_MASTER -- requirements
Module: opb_register_master

Interface
REQ-001 SHALL have parameter C_OPB_AWIDTH, default 32: OPB address width.
REQ-002 SHALL have parameter C_OPB_DWIDTH, default 32: OPB data width.
REQ-003 SHALL have parameter C_MAX_RETRIES, default 15: retry reissue limit.
REQ-004 SHALL have parameter C_WDOG_CYCLES, default 64: local no-response watchdog.
REQ-005 SHALL have ports (name  direction  width  meaning):
- OPB_Clk  in  1  sole clock; all logic on its rising edge.
- OPB_Rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  user command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  [31:0]  byte address.
- cmd_wdata  in  [31:0]  write data.
- cmd_be  in  [3:0]  byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  [31:0]  read data; 0 for writes and errors.
- rsp_status  out  [1:0]  0 OK, 1 ERR, 2 TIMEOUT, 3 RETRY.
- M_request  out  1  bus request to arbiter.
- M_select  out  1  master owns and drives bus.
- M_RNW  out  1  read/not-write.
- M_ABus  out  [0:31]  address, big-endian (M_ABus[i] = cmd_addr[31-i]).
- M_BE  out  [0:3]  byte enables, big-endian.
- M_DBus  out  [0:31]  write data; 0 on reads.
- OPB_MGrant  in  1  arbiter grant.
- OPB_DBus  in  [0:31]  read data from slaves.
- OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout  in  1 each  slave/bus responses.

Function
REQ-006 SHALL use states IDLE, REQ, XFER, BACKOFF, RESP; cmd_ready = 1 only in IDLE.
REQ-007 On accept, SHALL register the command and enter REQ next cycle; M_request = 1 only in REQ.
REQ-008 In REQ with OPB_MGrant = 1, SHALL enter XFER next cycle.
REQ-009 In XFER, SHALL hold M_select = 1 with stable M_RNW, M_ABus, M_BE, M_DBus; M_request = 0.
REQ-010 M_select, M_RNW, M_ABus, M_BE, M_DBus SHALL be all-zero outside XFER (OR-bus rule).
REQ-011 XFER response priority SHALL be timeout > retry > errAck > xferAck, sampled each cycle.
REQ-012 xferAck alone SHALL end XFER: status OK, read data captured from OPB_DBus, enter RESP next cycle.
REQ-013 errAck (with or without xferAck) SHALL end XFER with status ERR; OPB_timeout SHALL end it with status TIMEOUT.
REQ-014 Watchdog SHALL count cycles spent in REQ plus XFER, clearing on command accept; reaching C_WDOG_CYCLES SHALL give status TIMEOUT and drop M_request/M_select.
REQ-015 In RESP, rsp_valid = 1 with stable data/status until rsp_ready, then IDLE next cycle; back-to-back commands SHALL be accepted in that IDLE cycle.
REQ-016 Retry handling SHALL follow REQ-021.

Reset
REQ-017 While OPB_Rst_n = 0: state IDLE, all outputs 0 except cmd_ready = 1, counters 0.
REQ-018 Reset mid-transaction SHALL drop M_select/M_request immediately (asynchronously) and discard the command with no response.

Configuration
REQ-019 Macro OPB_REGISTER_MASTER_RETRY_EN SHALL select retry behaviour.
REQ-020 Without it, OPB_retry SHALL end the transaction with status RETRY.
REQ-021 With it, OPB_retry SHALL enter BACKOFF for 1 cycle (all bus outputs 0) then REQ; after C_MAX_RETRIES reissues, the next retry SHALL give status RETRY.

Structure
REQ-022 Package opb_register_master_pkg SHALL hold the state enum and rsp_status code constants.
REQ-023 The watchdog counter SHALL be sub-module opb_register_master_wdog (enable, clear, expired).

Verification
REQ-024 Write 0x0101_4300, data 0xDEAD_BEEF, BE 0xF, grant after 2 cycles, xferAck 3 cycles later -> M_ABus = 0x0101_4300 during XFER, status 0, bus outputs 0 afterwards.
REQ-025 Read 0x0101_4304, slave returns 0x1234_5678 with xferAck -> rsp_rdata = 0x1234_5678, status 0, M_DBus = 0 throughout.
REQ-026 errAck together with xferAck -> status 1, rsp_rdata = 0.
REQ-027 Grant never asserted -> status 2 exactly 64 cycles after accept, M_request low afterwards.
REQ-028 Retry on every attempt: with macro, 16 grants observed then status 3; without macro, status 3 after the first retry.
REQ-029 Reset asserted during XFER -> M_select = 0 in the same cycle; after release, cmd_ready = 1 and no rsp_valid.
